// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared encodings for the data-memory responder
package data_mem_responder_pkg;
    localparam logic [1:0]  WW_LOAD     = 2'b00;
    localparam logic [1:0]  WW_BYTE     = 2'b01;
    localparam logic [1:0]  WW_HALF     = 2'b10;
    localparam logic [1:0]  WW_WORD     = 2'b11;
    localparam logic [11:0] MMIO_CYCLE  = 12'h000;
    localparam logic [11:0] MMIO_TOHOST = 12'h004;
    localparam logic [31:0] MMIO_MASK   = 32'h0000_0FFF;
    localparam logic [1:0]  IDLE        = 2'd0;
    localparam logic [1:0]  WAIT        = 2'd1;
    localparam logic [1:0]  RESP        = 2'd2;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request-response bus with tohost mailbox
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_wwidth;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    modport master (
        output req_valid, req_addr, req_wdata, req_wwidth, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error, tohost_valid, tohost_data
    );
    modport slave (
        input  req_valid, req_addr, req_wdata, req_wwidth, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error, tohost_valid, tohost_data
    );
endinterface

// File: rtl/data_mem_responder_byte_ram.sv
// dmem_byte_ram: word RAM with lane-steered byte/half/word writes, async read
module dmem_byte_ram
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    wwidth,
    input  logic [1:0]    lane,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];
    logic [3:0]  be;
    logic [31:0] wd;

    // store data arrives LSB-aligned; replicate it so every lane sees its bytes
    always_comb begin
        be = wwidth == WW_BYTE ? 4'b0001 << lane :
             wwidth == WW_HALF ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = wwidth == WW_BYTE ? {4{wdata[7:0]}} :
             wwidth == WW_HALF ? {2{wdata[15:0]}} : wdata;
    end

    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (we && be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];

    assign rdata = mem[ridx];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder with cycle counter and tohost MMIO
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
    input  logic clk,
    input  logic reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(READ_LATENCY + 1);

    logic [1:0]    state;
    logic [CW-1:0] wcnt;
    logic [AW-1:0] idx_q, idx_sel;
    logic          mmio_q, mm_sel;
    logic [31:0]   cyc, rdata_q, th_d, ram_rd, rd_val;
    logic          err_q, th_v;
    logic          acc, ld, st, st_w, mmio, is0, is4, err, ram_we;

    always_comb begin
        acc    = bus.req_valid & bus.req_ready;
        ld     = bus.req_wwidth == WW_LOAD;
        st     = ~ld;
        st_w   = bus.req_wwidth == WW_WORD;
        mmio   = (bus.req_addr & ~MMIO_MASK) == MMIO_BASE;
        is0    = {bus.req_addr[11:2], 2'b00} == MMIO_CYCLE;
        is4    = {bus.req_addr[11:2], 2'b00} == MMIO_TOHOST;
        err    = (bus.req_wwidth == WW_HALF && bus.req_addr[0]) ||
                 (st_w && bus.req_addr[1:0] != 2'b00) ||
                 (!mmio && |bus.req_addr[31:AW+2]) ||
                 (mmio && (!(is0 || is4) || (st && is0) || (ld && is4) || (is4 && st && !st_w)));
        ram_we = acc & st & ~mmio & ~err;
        // in WAIT the captured request drives the read path, in IDLE the live one
        idx_sel = state == IDLE ? bus.req_addr[AW+1:2] : idx_q;
        mm_sel  = state == IDLE ? mmio : mmio_q;
        rd_val  = mm_sel ? cyc : ram_rd;
    end

    always_ff @(posedge clk)
        if (reset) begin
            state   <= IDLE;
            wcnt    <= '0;
            idx_q   <= '0;
            mmio_q  <= 1'b0;
            cyc     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            th_v    <= 1'b0;
            th_d    <= '0;
        end else begin
            cyc <= cyc + 32'd1;
            if (acc) begin
                idx_q   <= bus.req_addr[AW+1:2];
                mmio_q  <= mmio;
                wcnt    <= CW'(READ_LATENCY - 2);
                state   <= (ld && !err && READ_LATENCY > 1) ? WAIT : RESP;
                rdata_q <= (ld && !err) ? rd_val : '0;
                err_q   <= err;
                if (mmio && is4 && st_w && !err) begin
                    th_v <= 1'b1;
                    th_d <= bus.req_wdata;
                end
            end
            if (state == WAIT) begin
                wcnt <= wcnt - 1'b1;
                if (wcnt == '0) begin
                    state   <= RESP;
                    rdata_q <= rd_val;
                end
            end
            if (state == RESP && bus.resp_ready) state <= IDLE;
        end

    assign bus.req_ready    = state == IDLE;
    assign bus.resp_valid   = state == RESP;
    assign bus.resp_rdata   = rdata_q;
    assign bus.resp_error   = err_q;
    assign bus.tohost_valid = th_v;
    assign bus.tohost_data  = th_d;

    dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wwidth (bus.req_wwidth),
        .lane   (bus.req_addr[1:0]),
        .widx   (bus.req_addr[AW+1:2]),
        .wdata  (bus.req_wdata),
        .ridx   (idx_sel),
        .rdata  (ram_rd)
    );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of stores, loads, errors, MMIO and reset abort
module tb_data_mem_responder;
    localparam logic [1:0]  LD = 2'b00, BY = 2'b01, HF = 2'b10, WD = 2'b11;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(2), .MMIO_BASE(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                        output int unsigned t);
        int n = 0;
        bus.req_valid  = 1'b1;
        bus.req_wwidth = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        check("req_ready", {31'b0, bus.req_ready}, 1);
        step();
        t = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic get(output logic [31:0] rd, output logic er, output int lat);
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            step();
            lat++;
        end
        check("resp_valid", {31'b0, bus.resp_valid}, 1);
        rd = bus.resp_rdata;
        er = bus.resp_error;
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    task automatic xact(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        int unsigned t;
        send(w, a, d, t);
        get(rd, er, lat);
    endtask

    logic [31:0] rd, v1;
    logic        er;
    int          lat;
    int unsigned t1, t2;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_wwidth = LD;
        bus.resp_ready = 1'b0;
        repeat (3) step();
        check("rst_req_ready", {31'b0, bus.req_ready}, 1);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_error", {31'b0, bus.resp_error}, 0);
        check("rst_tohost_v", {31'b0, bus.tohost_valid}, 0);
        check("rst_tohost_d", bus.tohost_data, 0);
        reset = 1'b0;
        step();

        xact(WD, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("st_word_err", {31'b0, er}, 0);
        check("st_word_rdata", rd, 0);
        check("st_word_lat", lat, 1);
        xact(LD, 32'h10, 0, rd, er, lat);
        check("ld_word", rd, 32'hDEADBEEF);
        check("ld_word_err", {31'b0, er}, 0);
        check("ld_lat", lat, 2);

        xact(BY, 32'h11, 32'h123456AA, rd, er, lat);
        check("st_byte_err", {31'b0, er}, 0);
        xact(HF, 32'h12, 32'hABCD1234, rd, er, lat);
        check("st_half_err", {31'b0, er}, 0);
        xact(LD, 32'h10, 0, rd, er, lat);
        check("ld_merge", rd, 32'h1234AAEF);
        xact(BY, 32'h13, 32'hFFFFFF55, rd, er, lat);
        xact(LD, 32'h10, 0, rd, er, lat);
        check("ld_lane3", rd, 32'h5534AAEF);

        xact(WD, 32'h13, 32'h11111111, rd, er, lat);
        check("mis_word_err", {31'b0, er}, 1);
        check("mis_word_rdata", rd, 0);
        xact(HF, 32'h11, 32'h2222, rd, er, lat);
        check("mis_half_err", {31'b0, er}, 1);
        xact(LD, 32'h10, 0, rd, er, lat);
        check("mis_unchanged", rd, 32'h5534AAEF);

        send(LD, 32'h10, 0, t1);
        for (int n = 0; n < 50 && !bus.resp_valid; n++) step();
        bus.req_valid  = 1'b1;
        bus.req_wwidth = WD;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h77;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, bus.resp_valid}, 1);
            check("hold_rdata", bus.resp_rdata, 32'h5534AAEF);
            check("hold_ready", {31'b0, bus.req_ready}, 0);
            step();
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check("post_hs_ready", {31'b0, bus.req_ready}, 1);
        check("post_hs_valid", {31'b0, bus.resp_valid}, 0);
        step();
        bus.req_valid = 1'b0;
        check("held_accept", {31'b0, bus.resp_valid}, 1);
        get(rd, er, lat);
        check("held_err", {31'b0, er}, 0);
        xact(LD, 32'h20, 0, rd, er, lat);
        check("held_data", rd, 32'h77);

        xact(WD, MB + 4, 32'h1, rd, er, lat);
        check("tohost_err", {31'b0, er}, 0);
        check("tohost_v", {31'b0, bus.tohost_valid}, 1);
        check("tohost_d", bus.tohost_data, 1);
        xact(WD, MB + 4, 32'hCAFE, rd, er, lat);
        check("tohost_d2", bus.tohost_data, 32'hCAFE);
        xact(BY, MB + 4, 32'h99, rd, er, lat);
        check("tohost_byte_err", {31'b0, er}, 1);
        check("tohost_d_keep", bus.tohost_data, 32'hCAFE);
        check("tohost_v_keep", {31'b0, bus.tohost_valid}, 1);
        xact(WD, MB, 32'h5, rd, er, lat);
        check("st_cyc_err", {31'b0, er}, 1);
        xact(LD, MB + 4, 0, rd, er, lat);
        check("ld_tohost_err", {31'b0, er}, 1);
        check("ld_tohost_rdata", rd, 0);
        xact(LD, MB + 8, 0, rd, er, lat);
        check("mmio_off_err", {31'b0, er}, 1);

        send(LD, MB, 0, t1);
        get(v1, er, lat);
        check("cyc1_err", {31'b0, er}, 0);
        repeat (7) step();
        send(LD, MB, 0, t2);
        get(rd, er, lat);
        check("cyc_delta", rd - v1, t2 - t1);

        xact(LD, 32'h1000, 0, rd, er, lat);
        check("oor_ld_err", {31'b0, er}, 1);
        check("oor_ld_rdata", rd, 0);
        xact(WD, 32'hFFC, 32'h0BADF00D, rd, er, lat);
        check("last_st_err", {31'b0, er}, 0);
        xact(LD, 32'hFFC, 0, rd, er, lat);
        check("last_ld", rd, 32'h0BADF00D);

        send(LD, 32'h10, 0, t1);
        check("wait_no_valid", {31'b0, bus.resp_valid}, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_ready", {31'b0, bus.req_ready}, 1);
        check("abort_valid", {31'b0, bus.resp_valid}, 0);
        check("abort_tohost", {31'b0, bus.tohost_valid}, 0);
        repeat (3) step();
        check("abort_still", {31'b0, bus.resp_valid}, 0);
        xact(LD, 32'h10, 0, rd, er, lat);
        check("mem_kept", rd, 32'h5534AAEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
